id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection for the 5-stage MIPS pipeline.
- Sits directly upstream of the ALU. It captures decoded operands and control from ID, then drives the ALU's inp1, inp2 and func.
- It also supplies the store data, the destination register and the MEM/WB control bits to the EX/MEM register.

Parameters:
- N, 32, datapath width.
- RA, 5, register-address width.
- NOP_FUNC, 3'b011, ALU function code used for bubbles and reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the current EX contents (back-pressure from MEM).
- flush  in  1  replace the EX contents with a bubble (branch/jump taken).
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  RA  source and destination register numbers.
- id_rd1, id_rd2  in  N  register-file read data.
- id_imm  in  N  sign-extended immediate.
- id_alu_func  in  3  ALU function: ADD 010, SUB 110, AND 000, OR 001, SLT 111, NOP 011.
- id_alu_src  in  1  selects the ALU second operand: 1 = immediate, 0 = rt.
- id_reg_dst  in  1  selects the destination: 1 = rd, 0 = rt.
- id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write  in  1  downstream control bits.
- mem_reg_write  in  1  EX/MEM stage will write a register.
- mem_rd  in  RA  EX/MEM destination register.
- mem_alu_out  in  N  EX/MEM result.
- wb_reg_write  in  1  MEM/WB stage will write a register.
- wb_rd  in  RA  MEM/WB destination register.
- wb_data  in  N  MEM/WB write-back data.
- alu_inp1, alu_inp2  out  N  ALU operands.
- alu_func  out  3  ALU function.
- ex_store_data  out  N  forwarded rt value for stores.
- ex_dest  out  RA  selected destination register.
- ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_valid  out  1  registered control bits.
- load_use_hazard  out  1  request to ID/IF to hold (combinational).

Behaviour:
- Register update priority at each clk edge:
  - rst first: every register cleared to 0, and func loaded with NOP_FUNC.
  - then flush: load a bubble.
  - then stall: hold all registers.
  - then load_use_hazard: load a bubble.
  - otherwise: load all id_* inputs.
- Bubble contents: func = NOP_FUNC; valid, reg_write, mem_read and mem_write all 0; the other fields are don't-care but are driven to 0.
- Reset outputs: alu_func = 3'b011, all control outputs 0, ex_dest 0. The data outputs equal the forwarding result computed from the zeroed registers.
- ex_dest is computed at load time: reg_dst ? id_rd : id_rt.
- Forwarding is combinational, from the registered ex_rs/ex_rt. For each source register s:
  - if mem_reg_write, mem_rd == s and s != 0: use mem_alu_out;
  - else if wb_reg_write, wb_rd == s and s != 0: use wb_data;
  - else use the registered read data.
  - MEM always wins over WB.
  - Register $0 is never forwarded and always reads as the registered value (which is 0 from the register file).
- Operand selection:
  - alu_inp1 = fwd(rs).
  - alu_inp2 = alu_src ? imm : fwd(rt).
  - ex_store_data = fwd(rt), regardless of alu_src.
- Forwarding stays live during stall: held operands are re-forwarded as the MEM/WB values change.
- load_use_hazard = ex_valid & ex_mem_read & (ex_dest != 0) & ((ex_dest == id_rs) | (ex_dest == id_rt)) & id_valid.
  - Purely combinational, so there is zero-cycle latency to ID.
  - It asserts for exactly one cycle per load-use pair when there is no stall.
  - During a stall it may stay high. It has no effect because stall outranks it.
- flush and hazard in the same cycle: flush wins. Both produce a bubble, so the result is identical.
- Latency: one cycle from id_* to alu_*. There is no internal state other than the pipeline register.

Decomposition:
- Shared package holds:
  - the ALU function codes ADD, SUB, AND, OR, SLT, NOP;
  - RA and N;
  - a typedef for the ID/EX control bundle (mem_read, mem_write, mem_to_reg, reg_write, valid).
- One natural sub-module: fwd_mux.
  - Inputs: s, reg value, MEM and WB forwarding sources.
  - Output: the forwarded value.
  - Instantiated twice, once for rs and once for rt.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random id_* inputs. Required: alu_func=011, ex_reg_write=0, ex_valid=0, load_use_hazard=0.
- Plain load: ADD with rs=3 (rd1=5), rt=4 (rd2=7), alu_src=0, reg_dst=1, rd=9. Required next cycle: alu_inp1=5, alu_inp2=7, alu_func=010, ex_dest=9.
- Forwarding priority, rs=3 in EX:
  - mem_rd=3, mem_alu_out=100 and wb_rd=3, wb_data=200 both writing. Required: alu_inp1=100.
  - Drop mem_reg_write. Required: 200.
  - With rs=0 and mem_rd=0. Required: no forwarding.
- Load-use: EX holds lw with dest 8; ID holds add with rs=8. Required:
  - load_use_hazard=1 the same cycle;
  - next cycle alu_func=011, ex_valid=0;
  - the following cycle the add loads normally.
- Stall vs flush:
  - stall=1 for 3 cycles with changing id_*. Required: EX outputs hold, except that forwarding tracks mem_alu_out changes.
  - stall=1 and flush=1 together. Required: bubble loaded.
- Store forwarding: sw with alu_src=1, imm=16, rt=5, wb_rd=5, wb_data=0xDEAD. Required: alu_inp2=16, ex_store_data=0xDEAD.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU function codes, datapath widths
// and the control bundle carried from ID into EX.
package id_ex_stage_pkg;

  localparam int unsigned N  = 32;
  localparam int unsigned RA = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOP = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_func_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic valid;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux for one EX source register; the MEM result beats
// the WB result, and register $0 is never forwarded.
module fwd_mux #(
  parameter int unsigned N  = 32,
  parameter int unsigned RA = 5
) (
  input  logic [RA-1:0] s,
  input  logic [N-1:0]  reg_val,
  input  logic          mem_reg_write,
  input  logic [RA-1:0] mem_rd,
  input  logic [N-1:0]  mem_val,
  input  logic          wb_reg_write,
  input  logic [RA-1:0] wb_rd,
  input  logic [N-1:0]  wb_val,
  output logic [N-1:0]  fwd_val
);

  always_comb begin
    fwd_val = reg_val;
    if (s != '0) begin
      if (mem_reg_write && (mem_rd == s)) begin
        fwd_val = mem_val;
      end else if (wb_reg_write && (wb_rd == s)) begin
        fwd_val = wb_val;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection, feeding the ALU and the EX/MEM register.
module id_ex_stage #(
  parameter int unsigned N        = id_ex_stage_pkg::N,
  parameter int unsigned RA       = id_ex_stage_pkg::RA,
  parameter logic [2:0]  NOP_FUNC = id_ex_stage_pkg::ALU_NOP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RA-1:0] id_rs,
  input  logic [RA-1:0] id_rt,
  input  logic [RA-1:0] id_rd,
  input  logic [N-1:0]  id_rd1,
  input  logic [N-1:0]  id_rd2,
  input  logic [N-1:0]  id_imm,
  input  logic [2:0]    id_alu_func,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          id_reg_write,
  input  logic          mem_reg_write,
  input  logic [RA-1:0] mem_rd,
  input  logic [N-1:0]  mem_alu_out,
  input  logic          wb_reg_write,
  input  logic [RA-1:0] wb_rd,
  input  logic [N-1:0]  wb_data,
  output logic [N-1:0]  alu_inp1,
  output logic [N-1:0]  alu_inp2,
  output logic [2:0]    alu_func,
  output logic [N-1:0]  ex_store_data,
  output logic [RA-1:0] ex_dest,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_reg_write,
  output logic          ex_valid,
  output logic          load_use_hazard
);

  import id_ex_stage_pkg::*;

  logic [RA-1:0] rs_q, rs_d;
  logic [RA-1:0] rt_q, rt_d;
  logic [RA-1:0] dest_q, dest_d;
  logic [N-1:0]  rd1_q, rd1_d;
  logic [N-1:0]  rd2_q, rd2_d;
  logic [N-1:0]  imm_q, imm_d;
  logic [2:0]    func_q, func_d;
  logic          alu_src_q, alu_src_d;
  ctrl_t         ctrl_q, ctrl_d;

  logic [N-1:0]  fwd_rs, fwd_rt;

  assign load_use_hazard = ctrl_q.valid & ctrl_q.mem_read & (dest_q != '0) &
                           ((dest_q == id_rs) | (dest_q == id_rt)) & id_valid;

  always_comb begin
    rs_d      = rs_q;
    rt_d      = rt_q;
    dest_d    = dest_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    imm_d     = imm_q;
    func_d    = func_q;
    alu_src_d = alu_src_q;
    ctrl_d    = ctrl_q;
    // flush beats stall, stall beats the hazard; both bubble causes share one path
    if (flush || (!stall && load_use_hazard)) begin
      rs_d      = '0;
      rt_d      = '0;
      dest_d    = '0;
      rd1_d     = '0;
      rd2_d     = '0;
      imm_d     = '0;
      func_d    = NOP_FUNC;
      alu_src_d = 1'b0;
      ctrl_d    = '0;
    end else if (!stall) begin
      rs_d              = id_rs;
      rt_d              = id_rt;
      dest_d            = id_reg_dst ? id_rd : id_rt;
      rd1_d             = id_rd1;
      rd2_d             = id_rd2;
      imm_d             = id_imm;
      func_d            = id_alu_func;
      alu_src_d         = id_alu_src;
      ctrl_d.mem_read   = id_mem_read;
      ctrl_d.mem_write  = id_mem_write;
      ctrl_d.mem_to_reg = id_mem_to_reg;
      ctrl_d.reg_write  = id_reg_write;
      ctrl_d.valid      = id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q      <= '0;
      rt_q      <= '0;
      dest_q    <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      func_q    <= NOP_FUNC;
      alu_src_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      dest_q    <= dest_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      imm_q     <= imm_d;
      func_q    <= func_d;
      alu_src_q <= alu_src_d;
      ctrl_q    <= ctrl_d;
    end
  end

  fwd_mux #(.N(N), .RA(RA)) u_fwd_rs (
    .s             (rs_q),
    .reg_val       (rd1_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_val       (mem_alu_out),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_val        (wb_data),
    .fwd_val       (fwd_rs)
  );

  fwd_mux #(.N(N), .RA(RA)) u_fwd_rt (
    .s             (rt_q),
    .reg_val       (rd2_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_val       (mem_alu_out),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_val        (wb_data),
    .fwd_val       (fwd_rt)
  );

  assign alu_inp1      = fwd_rs;
  assign alu_inp2      = alu_src_q ? imm_q : fwd_rt;
  assign alu_func      = func_q;
  assign ex_store_data = fwd_rt;
  assign ex_dest       = dest_q;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_valid      = ctrl_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table walked cycle by cycle plus
// hand-written reset and multi-cycle stall sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [2:0]  id_alu_func;
  logic        id_alu_src, id_reg_dst;
  logic        id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_alu_out, wb_data;
  logic [31:0] alu_inp1, alu_inp2, ex_store_data;
  logic [2:0]  alu_func;
  logic [4:0]  ex_dest;
  logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_valid;
  logic        load_use_hazard;

  int unsigned pass_cnt = 0;
  int unsigned tot_cnt  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.N(32), .RA(5), .NOP_FUNC(3'b011)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_alu_func(id_alu_func), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_out(mem_alu_out),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_func(alu_func),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_valid(ex_valid), .load_use_hazard(load_use_hazard)
  );

  typedef struct {
    logic        stall, flush, vld;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic [2:0]  func;
    logic        src, dst;
    logic [3:0]  ctl;      // {mem_read, mem_write, mem_to_reg, reg_write}
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] mout;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        pre_haz;  // hazard expected before the edge
    logic [31:0] e_in1, e_in2, e_st;
    logic [2:0]  e_func;
    logic [4:0]  e_dest;
    logic [4:0]  e_ctl;    // {mem_read, mem_write, mem_to_reg, reg_write, valid}
  } vec_t;

  function automatic vec_t mk(
    input int stl, input int fl, input int vld,
    input int rs, input int rt, input int rd,
    input int rd1, input int rd2, input int imm,
    input int func, input int src, input int dst, input int ctl,
    input int mrw, input int mrd, input int mout,
    input int wrw, input int wrd, input int wdat,
    input int ph, input int in1, input int in2, input int st,
    input int efunc, input int edest, input int ectl);
    vec_t v;
    v.stall = 1'(stl);  v.flush = 1'(fl);  v.vld = 1'(vld);
    v.rs = 5'(rs);  v.rt = 5'(rt);  v.rd = 5'(rd);
    v.rd1 = rd1;  v.rd2 = rd2;  v.imm = imm;
    v.func = 3'(func);  v.src = 1'(src);  v.dst = 1'(dst);  v.ctl = 4'(ctl);
    v.mrw = 1'(mrw);  v.mrd = 5'(mrd);  v.mout = mout;
    v.wrw = 1'(wrw);  v.wrd = 5'(wrd);  v.wdat = wdat;
    v.pre_haz = 1'(ph);
    v.e_in1 = in1;  v.e_in2 = in2;  v.e_st = st;
    v.e_func = 3'(efunc);  v.e_dest = 5'(edest);  v.e_ctl = 5'(ectl);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall;  flush = v.flush;  id_valid = v.vld;
    id_rs = v.rs;  id_rt = v.rt;  id_rd = v.rd;
    id_rd1 = v.rd1;  id_rd2 = v.rd2;  id_imm = v.imm;
    id_alu_func = v.func;  id_alu_src = v.src;  id_reg_dst = v.dst;
    {id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write} = v.ctl;
    mem_reg_write = v.mrw;  mem_rd = v.mrd;  mem_alu_out = v.mout;
    wb_reg_write = v.wrw;  wb_rd = v.wrd;  wb_data = v.wdat;
  endtask

  task automatic randomize_inputs();
    stall = 1'($urandom);  flush = 1'($urandom);  id_valid = 1'($urandom);
    id_rs = 5'($urandom);  id_rt = 5'($urandom);  id_rd = 5'($urandom);
    id_rd1 = $urandom;  id_rd2 = $urandom;  id_imm = $urandom;
    id_alu_func = 3'($urandom);  id_alu_src = 1'($urandom);  id_reg_dst = 1'($urandom);
    id_mem_read = 1'($urandom);  id_mem_write = 1'($urandom);
    id_mem_to_reg = 1'($urandom);  id_reg_write = 1'($urandom);
    mem_reg_write = 1'($urandom);  mem_rd = 5'($urandom);  mem_alu_out = $urandom;
    wb_reg_write = 1'($urandom);  wb_rd = 5'($urandom);  wb_data = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vq[$];

    // 0 plain ADD; 1-2 MEM/WB priority then WB-only under stall; 3 rs=$0
    vq.push_back(mk(0,0,1, 3,4,9, 5,7,0, 2,0,1,'b0001, 0,0,0, 0,0,0, 0, 5,7,7, 2,9,'b00011));
    vq.push_back(mk(0,0,1, 3,4,9, 5,7,0, 2,0,1,'b0001, 1,3,100, 1,3,200, 0, 100,7,7, 2,9,'b00011));
    vq.push_back(mk(1,0,1, 10,11,12, 1,2,0, 6,0,1,'b0001, 0,3,100, 1,3,200, 0, 200,7,7, 2,9,'b00011));
    vq.push_back(mk(0,0,1, 0,4,9, 'h55,7,0, 1,0,1,'b0001, 1,0,100, 1,0,200, 0, 'h55,7,7, 1,9,'b00011));
    // 4 rs from MEM, rt from WB, reg_dst=0
    vq.push_back(mk(0,0,1, 6,7,12, 1,2,0, 6,0,0,'b0001, 1,6,'h300, 1,7,'h400, 0, 'h300,'h400,'h400, 6,7,'b00011));
    // 5-7 lw $8 then dependent add: bubble, then add with WB forward
    vq.push_back(mk(0,0,1, 2,8,0, 'h1000,0,4, 2,1,0,'b1011, 0,0,0, 0,0,0, 0, 'h1000,4,0, 2,8,'b10111));
    vq.push_back(mk(0,0,1, 8,3,10, 'h11,'h22,0, 2,0,1,'b0001, 0,0,0, 0,0,0, 1, 0,0,0, 3,0,'b00000));
    vq.push_back(mk(0,0,1, 8,3,10, 'h11,'h22,0, 2,0,1,'b0001, 0,0,0, 1,8,'hBEEF, 0, 'hBEEF,'h22,'h22, 2,10,'b00011));
    // 8 stall and flush together
    vq.push_back(mk(1,1,1, 4,5,6, 1,2,3, 6,0,1,'b0001, 0,0,0, 0,0,0, 0, 0,0,0, 3,0,'b00000));
    // 9 sw with immediate and WB-forwarded store data
    vq.push_back(mk(0,0,1, 1,5,0, 'h20,'h99,16, 2,1,0,'b0100, 0,0,0, 1,5,'hDEAD, 0, 'h20,16,'hDEAD, 2,5,'b01001));
    // 10-11 lw to $0 never raises a hazard
    vq.push_back(mk(0,0,1, 1,0,0, 'h40,0,8, 2,1,0,'b1011, 0,0,0, 0,0,0, 0, 'h40,8,0, 2,0,'b10111));
    vq.push_back(mk(0,0,1, 0,0,3, 0,0,0, 2,0,1,'b0001, 0,0,0, 0,0,0, 0, 0,0,0, 2,3,'b00011));
    // 12-13 hazard gated by id_valid
    vq.push_back(mk(0,0,1, 2,8,0, 'h1000,0,4, 2,1,0,'b1011, 0,0,0, 0,0,0, 0, 'h1000,4,0, 2,8,'b10111));
    vq.push_back(mk(0,0,0, 8,8,0, 0,0,0, 3,0,0,'b0000, 0,0,0, 0,0,0, 0, 0,0,0, 3,8,'b00000));
    // 14-17 stall outranks hazard, forwarding live while held, then bubble and reload
    vq.push_back(mk(0,0,1, 2,8,0, 'h1000,0,4, 2,1,0,'b1011, 0,0,0, 0,0,0, 0, 'h1000,4,0, 2,8,'b10111));
    vq.push_back(mk(1,0,1, 8,3,10, 'h11,'h22,0, 2,0,1,'b0001, 1,2,'h2000, 0,0,0, 1, 'h2000,4,0, 2,8,'b10111));
    vq.push_back(mk(0,0,1, 8,3,10, 'h11,'h22,0, 2,0,1,'b0001, 0,0,0, 0,0,0, 1, 0,0,0, 3,0,'b00000));
    vq.push_back(mk(0,0,1, 8,3,10, 'h11,'h22,0, 2,0,1,'b0001, 0,0,0, 0,0,0, 0, 'h11,'h22,'h22, 2,10,'b00011));

    // Reset held for two cycles with random inputs
    rst = 1'b1;
    randomize_inputs();
    @(posedge clk);
    @(negedge clk);
    randomize_inputs();
    @(posedge clk);
    #1;
    chk("rst alu_func", 32'(alu_func), 32'h3);
    chk("rst ex_reg_write", 32'(ex_reg_write), 32'h0);
    chk("rst ex_valid", 32'(ex_valid), 32'h0);
    chk("rst load_use_hazard", 32'(load_use_hazard), 32'h0);
    chk("rst ex_dest", 32'(ex_dest), 32'h0);
    chk("rst alu_inp1", alu_inp1, 32'h0);
    chk("rst ctrl", 32'({ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #1;
      chk($sformatf("v%0d hazard", i), 32'(load_use_hazard), 32'(vq[i].pre_haz));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d alu_inp1", i), alu_inp1, vq[i].e_in1);
      chk($sformatf("v%0d alu_inp2", i), alu_inp2, vq[i].e_in2);
      chk($sformatf("v%0d store", i), ex_store_data, vq[i].e_st);
      chk($sformatf("v%0d alu_func", i), 32'(alu_func), 32'(vq[i].e_func));
      chk($sformatf("v%0d ex_dest", i), 32'(ex_dest), 32'(vq[i].e_dest));
      chk($sformatf("v%0d ctrl", i),
          32'({ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_valid}),
          32'(vq[i].e_ctl));
      @(negedge clk);
    end

    // EX holds add rs=8 rt=3; three stall cycles with noisy ID and moving MEM result
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1'b1;
      flush = 1'b0;
      mem_reg_write = 1'b1;
      mem_rd = 5'd8;
      mem_alu_out = 32'h1000 + 32'(i);
      wb_reg_write = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d alu_inp1", i), alu_inp1, 32'h1000 + 32'(i));
      chk($sformatf("stall%0d alu_inp2", i), alu_inp2, 32'h22);
      chk($sformatf("stall%0d alu_func", i), 32'(alu_func), 32'h2);
      chk($sformatf("stall%0d ex_dest", i), 32'(ex_dest), 32'd10);
      chk($sformatf("stall%0d ex_valid", i), 32'(ex_valid), 32'h1);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
